// File: rtl/gpu_fb_pkg.sv
// Shared definitions for the pixel framebuffer and the 2D line engine.
//   DIM      : bitmap width/height in pixels (power of 2)
//   ROW_W    : row/column index width
//   COORD_W  : width of incoming pixel coordinates
//   coord_t  : pixel coordinate type shared with the line engine
//   pixel_t  : (x,y) coordinate pair
//   fb_state_t : framebuffer controller states
package gpu_fb_pkg;

  localparam int DIM     = 64;
  localparam int ROW_W   = $clog2(DIM);
  localparam int COORD_W = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } fb_state_t;

endpackage

// File: rtl/fb_bitmap.sv
// DIM x DIM 1-bpp bitmap held in flops.
//   clk, n_rst          : clock, async active-low reset (clears every bit)
//   i_wr_en/x/y         : set bit [y][x]
//   i_clr_en/i_clr_row  : zero one whole row
//   i_rd_row/o_rd_data  : combinational row read
module fb_bitmap
  import gpu_fb_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_wr_en,
  input  logic [ROW_W-1:0] i_wr_x,
  input  logic [ROW_W-1:0] i_wr_y,
  input  logic             i_clr_en,
  input  logic [ROW_W-1:0] i_clr_row,
  input  logic [ROW_W-1:0] i_rd_row,
  output logic [DIM-1:0]   o_rd_data
);

  logic [DIM-1:0] r_mem [DIM];

  // Write and row-clear are never active together: writes happen only in
  // IDLE and clears only in CLEAR.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DIM; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_clr_en) begin
        r_mem[i_clr_row] <= '0;
      end
      if (i_wr_en) begin
        r_mem[i_wr_y][i_wr_x] <= 1'b1;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_row];

endmodule

// File: rtl/pixel_framebuffer.sv
// Pixel sink and bitmap store for the 2D line engine.
//   clk, n_rst            : clock, async active-low reset
//   px_valid/ready/x/y    : pixel write handshake
//   clear_req, scan_start : single-cycle command pulses (clear wins)
//   busy                  : high in CLEAR, SCAN, DONE
//   row_valid/ready/idx/data : row scan-out stream
//   scan_done             : one-cycle pulse after the last row is taken
//   drop_cnt              : saturating count of out-of-range pixels
//
// state | meaning
// IDLE  | accept pixels, wait for clear_req / scan_start
// CLEAR | zero one row per cycle, rows 0..DIM-1
// SCAN  | present row[cnt], advance on row handshake
// DONE  | one-cycle scan_done pulse
module pixel_framebuffer
  import gpu_fb_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               px_valid,
  output logic               px_ready,
  input  logic [COORD_W-1:0] px_x,
  input  logic [COORD_W-1:0] px_y,
  input  logic               clear_req,
  input  logic               scan_start,
  output logic               busy,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [ROW_W-1:0]   row_idx,
  output logic [DIM-1:0]     row_data,
  output logic               scan_done,
  output logic [7:0]         drop_cnt
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);
  localparam coord_t           DIM_C    = COORD_W'(DIM);

  fb_state_t        r_state;
  fb_state_t        w_state_nxt;
  logic [ROW_W-1:0] r_cnt;
  logic [7:0]       r_drop_cnt;

  logic w_px_fire;
  logic w_in_range;
  logic w_wr_en;
  logic w_row_fire;
  logic w_last;
  logic w_clr_en;

  // Range check on the full coordinate width so e.g. x=64+3 is not aliased
  // onto column 3.
  assign w_px_fire  = px_valid && px_ready;
  assign w_in_range = (px_x < DIM_C) && (px_y < DIM_C);
  assign w_wr_en    = w_px_fire && w_in_range;
  assign w_row_fire = row_valid && row_ready;
  assign w_last     = (r_cnt == LAST_ROW);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (clear_req) begin
          w_state_nxt = CLEAR;
        end else if (scan_start) begin
          w_state_nxt = SCAN;
        end
      end
      CLEAR: begin
        if (w_last) begin
          w_state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (w_row_fire && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Outputs depend on state only, so px_ready has no path from px_valid.
  always_comb begin
    px_ready  = 1'b0;
    busy      = 1'b1;
    row_valid = 1'b0;
    scan_done = 1'b0;
    w_clr_en  = 1'b0;
    unique case (r_state)
      IDLE: begin
        px_ready = 1'b1;
        busy     = 1'b0;
      end
      CLEAR: begin
        w_clr_en = 1'b1;
      end
      SCAN: begin
        row_valid = 1'b1;
      end
      DONE: begin
        scan_done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Row counter: one step per cycle in CLEAR, one step per handshake in SCAN;
  // wraps to 0 after the last row so IDLE/DONE always see 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        SCAN: begin
          if (w_row_fire) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_drop_cnt <= '0;
    end else if (w_px_fire && !w_in_range && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  fb_bitmap u_bitmap (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_wr_en   (w_wr_en),
    .i_wr_x    (px_x[ROW_W-1:0]),
    .i_wr_y    (px_y[ROW_W-1:0]),
    .i_clr_en  (w_clr_en),
    .i_clr_row (r_cnt),
    .i_rd_row  (r_cnt),
    .o_rd_data (row_data)
  );

  assign row_idx  = r_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed self-checking bench for pixel_framebuffer.
module tb_pixel_framebuffer;
  import gpu_fb_pkg::*;

  logic               clk = 1'b0;
  logic               n_rst;
  logic               px_valid;
  logic               px_ready;
  logic [COORD_W-1:0] px_x;
  logic [COORD_W-1:0] px_y;
  logic               clear_req;
  logic               scan_start;
  logic               busy;
  logic               row_valid;
  logic               row_ready;
  logic [ROW_W-1:0]   row_idx;
  logic [DIM-1:0]     row_data;
  logic               scan_done;
  logic [7:0]         drop_cnt;

  logic [63:0] model [64];
  int          d_exp;
  int          n_chk;
  int          n_pass;

  always #5 clk = ~clk;

  pixel_framebuffer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_x       (px_x),
    .px_y       (px_y),
    .clear_req  (clear_req),
    .scan_start (scan_start),
    .busy       (busy),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_idx    (row_idx),
    .row_data   (row_data),
    .scan_done  (scan_done),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_px(input int x, input int y);
    px_valid = 1'b1;
    px_x     = x[7:0];
    px_y     = y[7:0];
    #1;
    chk("px_ready_idle", {63'd0, px_ready}, 64'd1);
    step();
    px_valid = 1'b0;
    if (x < 64 && y < 64) model[y][x] = 1'b1;
    else if (d_exp < 255) d_exp++;
  endtask

  // Full scan with row_ready held high; checks every row and the DONE cycle.
  task automatic run_scan(input string tag);
    row_ready  = 1'b1;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int r = 0; r < 64; r++) begin
      chk({tag, "_idx"},   {58'd0, row_idx}, 64'(r));
      chk({tag, "_data"},  row_data, model[r]);
      chk({tag, "_valid"}, {63'd0, row_valid}, 64'd1);
      chk({tag, "_nodone"}, {63'd0, scan_done}, 64'd0);
      step();
    end
    chk({tag, "_done"},      {63'd0, scan_done}, 64'd1);
    chk({tag, "_done_busy"}, {63'd0, busy}, 64'd1);
    chk({tag, "_done_rv"},   {63'd0, row_valid}, 64'd0);
    step();
    chk({tag, "_idle_done"}, {63'd0, scan_done}, 64'd0);
    chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_px_ready"}, {63'd0, px_ready}, 64'd1);
    chk({tag, "_busy"},     {63'd0, busy}, 64'd0);
    chk({tag, "_rv"},       {63'd0, row_valid}, 64'd0);
    chk({tag, "_done"},     {63'd0, scan_done}, 64'd0);
    chk({tag, "_idx"},      {58'd0, row_idx}, 64'd0);
    chk({tag, "_drop"},     {56'd0, drop_cnt}, 64'd0);
  endtask

  initial begin
    logic [3:0] pat;
    int         exp_idx;
    int         k;

    pat        = 4'b1001;
    n_chk      = 0;
    n_pass     = 0;
    d_exp      = 0;
    n_rst      = 1'b0;
    px_valid   = 1'b0;
    px_x       = '0;
    px_y       = '0;
    clear_req  = 1'b0;
    scan_start = 1'b0;
    row_ready  = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = '0;

    #12;
    chk_reset_outputs("rst");
    @(negedge clk);
    n_rst = 1'b1;
    step();

    run_scan("scan0");

    wr_px(3, 5);
    wr_px(63, 63);
    wr_px(0, 0);
    run_scan("scan1");

    wr_px(64, 2);
    wr_px(10, 200);
    chk("drop2", {56'd0, drop_cnt}, 64'(d_exp));
    chk("drop2_const", {56'd0, drop_cnt}, 64'd2);
    run_scan("scan_drop");
    for (int i = 0; i < 300; i++) wr_px(255, 255 - (i % 100));
    chk("drop_sat", {56'd0, drop_cnt}, 64'd255);

    // Clear and scan together: clear wins, scan is dropped.
    wr_px(7, 9);
    wr_px(40, 33);
    clear_req  = 1'b1;
    scan_start = 1'b1;
    step();
    clear_req  = 1'b0;
    scan_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) scan_start = 1'b1;
      chk("clr_busy",     {63'd0, busy}, 64'd1);
      chk("clr_px_ready", {63'd0, px_ready}, 64'd0);
      chk("clr_rv",       {63'd0, row_valid}, 64'd0);
      step();
      scan_start = 1'b0;
    end
    chk("clr_end_busy", {63'd0, busy}, 64'd0);
    chk("clr_end_rdy",  {63'd0, px_ready}, 64'd1);
    step();
    chk("clr_noscan",   {63'd0, row_valid}, 64'd0);
    for (int i = 0; i < 64; i++) model[i] = '0;
    run_scan("scan_clr");

    // Stalled scan with a pixel arriving alongside scan_start and another
    // held pending through the scan.
    wr_px(5, 7);
    scan_start = 1'b1;
    px_valid   = 1'b1;
    px_x       = 8'd1;
    px_y       = 8'd1;
    step();
    scan_start = 1'b0;
    model[1][1] = 1'b1;
    px_x       = 8'd2;
    exp_idx    = 0;
    k          = 0;
    while (exp_idx < 64 && k < 400) begin
      row_ready = pat[k % 4];
      #1;
      chk("stall_px_ready", {63'd0, px_ready}, 64'd0);
      chk("stall_idx",  {58'd0, row_idx}, 64'(exp_idx));
      chk("stall_data", row_data, model[exp_idx]);
      if (row_ready) exp_idx++;
      step();
      k++;
    end
    chk("stall_done",     {63'd0, scan_done}, 64'd1);
    chk("stall_done_rdy", {63'd0, px_ready}, 64'd0);
    step();
    chk("post_done_rdy",  {63'd0, px_ready}, 64'd1);
    step();
    px_valid = 1'b0;
    model[1][2] = 1'b1;
    row_ready = 1'b1;

    // Reset in the middle of a scan.
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int r = 0; r < 20; r++) begin
      chk("pre_rst_data", row_data, model[r]);
      step();
    end
    chk("pre_rst_idx", {58'd0, row_idx}, 64'd20);
    n_rst = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clk);
    n_rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_nodone", {63'd0, scan_done}, 64'd0);
      chk("post_rst_busy",   {63'd0, busy}, 64'd0);
      step();
    end
    for (int i = 0; i < 64; i++) model[i] = '0;
    d_exp = 0;
    run_scan("scan_rst");
    chk("final_drop", {56'd0, drop_cnt}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
